// File: rtl/kiwi_dense_layer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kiwi_dense_layer_seq : time-multiplexed dense layer, OUT_SIZE MACs over  |
// | IN_SIZE inputs, valid/ready on both sides. Optional ReLU: KIWI_RELU_EN   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module kiwi_dense_layer_seq #(
    parameter int IN_SIZE    = 4,
    parameter int OUT_SIZE   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [IN_SIZE*DATA_WIDTH-1:0]          in_vec,
    input  logic [OUT_SIZE*IN_SIZE*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_SIZE*DATA_WIDTH-1:0]         biases_flat,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_SIZE*DATA_WIDTH-1:0]         out_vec,
    output logic [OUT_SIZE-1:0]                    sat_mask,
    output logic                                   busy
);

    localparam int c_IDX_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int c_PROD_W = 2 * DATA_WIDTH;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(IN_SIZE - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    generate
        if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(IN_SIZE) + 1) begin : g_acc_width_check
            $fatal(1, "kiwi_dense_layer_seq: ACC_WIDTH too small for IN_SIZE/DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                          r_state;
    logic                            r_in_ready;
    logic                            r_out_valid;
    logic                            r_busy;
    logic [c_IDX_W-1:0]              r_idx;
    logic signed [DATA_WIDTH-1:0]    r_x [IN_SIZE];
    logic signed [ACC_WIDTH-1:0]     r_acc [OUT_SIZE];
    logic [OUT_SIZE*DATA_WIDTH-1:0]  r_out_vec;
    logic [OUT_SIZE-1:0]             r_sat_mask;

    logic signed [DATA_WIDTH-1:0]    w_weight [OUT_SIZE][IN_SIZE];
    logic signed [ACC_WIDTH-1:0]     w_bias_ext [OUT_SIZE];
    logic signed [ACC_WIDTH-1:0]     w_acc_next [OUT_SIZE];
    logic [OUT_SIZE*DATA_WIDTH-1:0]  w_result;
    logic [OUT_SIZE-1:0]             w_sat;

    for (genvar gi = 0; gi < OUT_SIZE; gi++) begin : g_row
        logic signed [c_PROD_W-1:0]   w_prod;
        logic signed [ACC_WIDTH-1:0]  w_shift;
        logic [DATA_WIDTH-1:0]        w_row_y;
        logic                         w_row_sat;

        for (genvar gj = 0; gj < IN_SIZE; gj++) begin : g_col
            assign w_weight[gi][gj] = weights_flat[(gi*IN_SIZE+gj)*DATA_WIDTH +: DATA_WIDTH];
        end

        assign w_bias_ext[gi] = {{(ACC_WIDTH-DATA_WIDTH){biases_flat[(gi+1)*DATA_WIDTH-1]}},
                                 biases_flat[gi*DATA_WIDTH +: DATA_WIDTH]};

        // One MAC per output row; the shared index walks the input vector.
        assign w_prod         = w_weight[gi][r_idx] * r_x[r_idx];
        assign w_acc_next[gi] = r_acc[gi] + {{(ACC_WIDTH-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
        assign w_shift        = w_acc_next[gi] >>> FRAC_BITS;

        always_comb begin
            w_row_sat = 1'b0;
            w_row_y   = w_shift[DATA_WIDTH-1:0];
            if (w_shift > c_SAT_MAX) begin
                w_row_sat = 1'b1;
                w_row_y   = c_SAT_MAX[DATA_WIDTH-1:0];
            end else if (w_shift < c_SAT_MIN) begin
                w_row_sat = 1'b1;
                w_row_y   = c_SAT_MIN[DATA_WIDTH-1:0];
            end
`ifdef KIWI_RELU_EN
            // Saturation flag is kept even when ReLU clears the value.
            if (w_row_y[DATA_WIDTH-1]) begin
                w_row_y = '0;
            end
`endif
        end

        assign w_result[gi*DATA_WIDTH +: DATA_WIDTH] = w_row_y;
        assign w_sat[gi] = w_row_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_out_vec   <= '0;
            r_sat_mask  <= '0;
            for (int i = 0; i < OUT_SIZE; i++) r_acc[i] <= '0;
            for (int j = 0; j < IN_SIZE; j++)  r_x[j]   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        for (int j = 0; j < IN_SIZE; j++)  r_x[j]   <= in_vec[j*DATA_WIDTH +: DATA_WIDTH];
                        for (int i = 0; i < OUT_SIZE; i++) r_acc[i] <= w_bias_ext[i];
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_MAC;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_MAC: begin
                    for (int i = 0; i < OUT_SIZE; i++) r_acc[i] <= w_acc_next[i];
                    r_idx <= r_idx + c_IDX_W'(1);
                    if (r_idx == c_LAST_IDX) begin
                        r_out_vec   <= w_result;
                        r_sat_mask  <= w_sat;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;
    assign sat_mask  = r_sat_mask;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_kiwi_dense_layer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_kiwi_dense_layer_seq : self-checking bench, FRAC_BITS=0 and =4 copies |
// | driven in lockstep. Rev 1.0                                              |
// +--------------------------------------------------------------------------+
module tb_kiwi_dense_layer_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [31:0]  in_vec;
    logic [127:0] weights_flat;
    logic [31:0]  biases_flat;
    logic         in_ready, out_valid, busy;
    logic [31:0]  out_vec;
    logic [3:0]   sat_mask;
    logic         in_ready_f, out_valid_f, busy_f;
    logic [31:0]  out_vec_f;
    logic [3:0]   sat_mask_f;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kiwi_dense_layer_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .weights_flat(weights_flat), .biases_flat(biases_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .sat_mask(sat_mask), .busy(busy)
    );

    kiwi_dense_layer_seq #(
        .IN_SIZE(4), .OUT_SIZE(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .FRAC_BITS(4)
    ) dut_frac (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
        .in_vec(in_vec), .weights_flat(weights_flat), .biases_flat(biases_flat),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_vec(out_vec_f),
        .sat_mask(sat_mask_f), .busy(busy_f)
    );

    typedef struct {
        logic [31:0]  x;
        logic [127:0] w;
        logic [31:0]  b;
        bit           frac4;
        logic [31:0]  exp_y;
        logic [3:0]   exp_s;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot product, floor shift, clamp, optional ReLU.
    function automatic void model(input logic [31:0] x, input logic [127:0] w,
                                  input logic [31:0] b, input int frac,
                                  output logic [31:0] y, output logic [3:0] s);
        logic signed [7:0] t;
        int acc, r, wv, xv;
        y = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            t = b[i*8 +: 8];
            acc = t;
            for (int j = 0; j < 4; j++) begin
                t  = w[(i*4+j)*8 +: 8];
                wv = t;
                t  = x[j*8 +: 8];
                xv = t;
                acc += wv * xv;
            end
            r = acc >>> frac;
            if (r > 127) begin
                r = 127;
                s[i] = 1'b1;
            end else if (r < -128) begin
                r = -128;
                s[i] = 1'b1;
            end
`ifdef KIWI_RELU_EN
            if (r < 0) r = 0;
`endif
            y[i*8 +: 8] = r[7:0];
        end
    endfunction

    // mode 0: diagonal v, 1: all v, 2: alternating +1/-1 by (i+j) parity
    function automatic logic [127:0] mk_w(input int mode, input logic [7:0] v);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                case (mode)
                    0:       if (i == j) w[(i*4+j)*8 +: 8] = v;
                    1:       w[(i*4+j)*8 +: 8] = v;
                    default: w[(i*4+j)*8 +: 8] = ((i + j) % 2 != 0) ? 8'h01 : 8'hFF;
                endcase
        return w;
    endfunction

    task automatic run_txn(input logic [31:0] x, input logic [127:0] w, input logic [31:0] b,
                           input int hold,
                           output logic [31:0] y, output logic [3:0] s,
                           output logic [31:0] yf, output logic [3:0] sf);
        int guard;
        int lat;
        bit stable;
        in_vec = x;
        weights_flat = w;
        biases_flat = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 32'd4);
        y  = out_vec;
        s  = sat_mask;
        yf = out_vec_f;
        sf = sat_mask_f;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            in_vec = $urandom;
            @(posedge clk); #1;
            if (out_vec !== y || sat_mask !== s || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_vec_f !== yf || busy !== 1'b1)
                stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] y, yf, ey, eyf;
        logic [3:0]  s, sf, es, esf;
        logic [31:0] rx, rb;
        logic [127:0] rw;

        tbl[0] = '{32'h01010101, mk_w(0, 8'h01), 32'h0, 1'b0, 32'h01010101, 4'h0};
        tbl[1] = '{32'h7F7F7F7F, mk_w(1, 8'h7F), 32'h0, 1'b0, 32'h7F7F7F7F, 4'hF};
        tbl[2] = '{32'hAAAAAAAA, mk_w(2, 8'h00), 32'h05050505, 1'b0, 32'h05050505, 4'h0};
`ifdef KIWI_RELU_EN
        tbl[3] = '{32'h01010101, mk_w(1, 8'hFF), 32'h0, 1'b0, 32'h00000000, 4'h0};
        tbl[5] = '{32'hF8F8F8F8, mk_w(0, 8'h01), 32'h0, 1'b1, 32'h00000000, 4'h0};
`else
        tbl[3] = '{32'h01010101, mk_w(1, 8'hFF), 32'h0, 1'b0, 32'hFCFCFCFC, 4'h0};
        tbl[5] = '{32'hF8F8F8F8, mk_w(0, 8'h01), 32'h0, 1'b1, 32'hFFFFFFFF, 4'h0};
`endif
        tbl[4] = '{32'h20202020, mk_w(0, 8'h10), 32'h0, 1'b1, 32'h20202020, 4'h0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_vec = '0;
        weights_flat = '0;
        biases_flat = '0;
        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_vec", out_vec, 32'd0);
        chk("reset_sat_mask", {28'd0, sat_mask}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_first_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("in_ready_first_edge", {31'd0, in_ready}, 32'd1);

        // Directed table
        for (int t = 0; t < 6; t++) begin
            run_txn(tbl[t].x, tbl[t].w, tbl[t].b, 0, y, s, yf, sf);
            if (tbl[t].frac4) begin
                chk($sformatf("tbl%0d_frac_y", t), yf, tbl[t].exp_y);
                chk($sformatf("tbl%0d_frac_sat", t), {28'd0, sf}, {28'd0, tbl[t].exp_s});
            end else begin
                chk($sformatf("tbl%0d_y", t), y, tbl[t].exp_y);
                chk($sformatf("tbl%0d_sat", t), {28'd0, s}, {28'd0, tbl[t].exp_s});
            end
            model(tbl[t].x, tbl[t].w, tbl[t].b, 0, ey, es);
            model(tbl[t].x, tbl[t].w, tbl[t].b, 4, eyf, esf);
            chk($sformatf("tbl%0d_model_y", t), y, ey);
            chk($sformatf("tbl%0d_model_frac_y", t), yf, eyf);
        end

        // Back-pressure: 10 held cycles, then the next vector must be correct
        run_txn(tbl[0].x, tbl[0].w, tbl[0].b, 10, y, s, yf, sf);
        chk("bp_y", y, 32'h01010101);
        chk("bp_sat", {28'd0, s}, 32'd0);
        run_txn(tbl[2].x, tbl[2].w, tbl[2].b, 0, y, s, yf, sf);
        chk("bp_next_y", y, 32'h05050505);

        // Mid-MAC reset after a saturating result is left on the outputs
        run_txn(tbl[1].x, tbl[1].w, tbl[1].b, 0, y, s, yf, sf);
        chk("pre_reset_y", y, 32'h7F7F7F7F);
        in_vec = tbl[0].x;
        weights_flat = tbl[0].w;
        biases_flat = tbl[0].b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_vec", out_vec, 32'd0);
        chk("rst_sat_mask", {28'd0, sat_mask}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frac_out_vec", out_vec_f, 32'd0);
        @(posedge clk); #1;
        chk("rst_in_ready_held", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_release", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_in_ready_edge", {31'd0, in_ready}, 32'd1);
        chk("rst_no_partial", {31'd0, out_valid}, 32'd0);
        run_txn(tbl[0].x, tbl[0].w, tbl[0].b, 0, y, s, yf, sf);
        chk("post_reset_y", y, 32'h01010101);
        chk("post_reset_sat", {28'd0, s}, 32'd0);

        // Randomized vectors against the reference model
        for (int n = 0; n < 24; n++) begin
            rx = $urandom;
            rb = $urandom;
            rw = {$urandom, $urandom, $urandom, $urandom};
            if (n % 4 == 0) rb = 32'h0;
            run_txn(rx, rw, rb, int'($urandom_range(0, 3)), y, s, yf, sf);
            model(rx, rw, rb, 0, ey, es);
            model(rx, rw, rb, 4, eyf, esf);
            chk($sformatf("rnd%0d_y", n), y, ey);
            chk($sformatf("rnd%0d_sat", n), {28'd0, s}, {28'd0, es});
            chk($sformatf("rnd%0d_frac_y", n), yf, eyf);
            chk($sformatf("rnd%0d_frac_sat", n), {28'd0, sf}, {28'd0, esf});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kiwi_dense_layer_seq.md
Name: kiwi_dense_layer_seq

Overview:
Sequential, time-multiplexed dense (fully-connected) layer engine for KiwiNPU, the next step beyond the combinational per-layer datapath. It computes out[i] = act(sat((bias[i] + sum_j w[i][j]*x[j]) >>> FRAC_BITS)) with OUT_SIZE parallel MACs iterating over the IN_SIZE inputs. It uses a valid/ready handshake on input and output so layers can be chained with back-pressure.

Parameters:
IN_SIZE, 4, number of input neurons (>=1)
OUT_SIZE, 4, number of output neurons / parallel MACs (>=1)
DATA_WIDTH, 8, signed two's-complement width of inputs, weights, biases and outputs
ACC_WIDTH, 32, signed accumulator width; must be >= 2*DATA_WIDTH + $clog2(IN_SIZE) + 1 (elaboration-time check, $fatal if violated)
FRAC_BITS, 0, arithmetic right shift applied to the accumulator before saturation (fixed-point Q format)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_vec is valid
in_ready  out  1  block can accept in_vec
in_vec  in  IN_SIZE*DATA_WIDTH  x[j] at [j*DATA_WIDTH +: DATA_WIDTH]
weights_flat  in  OUT_SIZE*IN_SIZE*DATA_WIDTH  w[i][j] at [(i*IN_SIZE+j)*DATA_WIDTH +: DATA_WIDTH]
biases_flat  in  OUT_SIZE*DATA_WIDTH  bias[i] at [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  out_vec and sat_mask are valid
out_ready  in  1  downstream accepts out_vec
out_vec  out  OUT_SIZE*DATA_WIDTH  y[i] at [i*DATA_WIDTH +: DATA_WIDTH], registered
sat_mask  out  OUT_SIZE  bit i set if y[i] was saturated
busy  out  1  high in MAC or OUT state

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_vec=0, sat_mask=0, busy=0, accumulators=0, index=0.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts and is high only in IDLE.
- FSM states IDLE, MAC, OUT:
  - IDLE: on the edge with in_valid&in_ready, capture in_vec, set acc[i] <= sign-extended bias[i], j <= 0, in_ready <= 0, go to MAC.
  - MAC: each edge, acc[i] += w[i][j]*x[j] (full 2*DATA_WIDTH signed product, sign-extended), j++.
    - On the edge where j==IN_SIZE-1, register the final results into out_vec/sat_mask, set out_valid <= 1, go to OUT.
  - OUT: out_vec, sat_mask and out_valid are held stable until out_valid&out_ready. On that edge out_valid <= 0, in_ready <= 1, go to IDLE.
- Latency: out_valid rises exactly IN_SIZE edges after the accept edge. Throughput is one vector per IN_SIZE+2 cycles; no overlap between transactions.
- Final result: r = (acc_final >>> FRAC_BITS), an arithmetic shift with floor rounding.
  - r > 2^(DW-1)-1 gives 2^(DW-1)-1 with sat_mask[i]=1.
  - r < -2^(DW-1) gives -2^(DW-1) with sat_mask[i]=1.
  - Otherwise y[i] = r[DW-1:0] with sat_mask[i]=0.
- Accumulator never wraps; the ACC_WIDTH constraint guarantees this.
- weights_flat and biases_flat are sampled live during MAC. The upstream keeps them stable while busy=1; behaviour is undefined otherwise.
- in_valid while in_ready=0 is ignored and causes no state change.
- Reset asserted mid-operation (any state) immediately returns all outputs to reset values and aborts the transaction; no partial result appears.
- IN_SIZE=1: MAC lasts one edge and out_valid rises on the edge after accept.

Optional Feature:
KIWI_RELU_EN
- Defined: ReLU is applied after saturation, so negative y[i] becomes 0. sat_mask still reports saturation computed before ReLU (negative saturation sets the bit and gives y=0).
- Undefined: output is signed saturated value, no activation.

Test Plan:
All scenarios use defaults (IN=OUT=4, DW=8, FRAC=0) unless stated.

1. Identity weights, bias 0, in_vec=32'h01010101 -> out_vec=32'h01010101, sat_mask=4'h0, out_valid exactly 4 edges after accept edge.
2. All weights 8'h7F, bias 0, in_vec=32'h7F7F7F7F (sum 64516) -> out_vec=32'h7F7F7F7F, sat_mask=4'hF.
3. Weights w[i][j]=((i+j)%2)?8'h01:8'hFF, bias 8'h05, in_vec=32'hAAAAAAAA -> each row sums to 0 -> out_vec=32'h05050505. Then all weights 8'hFF, bias 0, in_vec=32'h01010101 -> out_vec=32'hFCFCFCFC without KIWI_RELU_EN, 32'h00000000 with it; sat_mask=0.
4. Back-pressure: hold out_ready=0 for 10 cycles in OUT, toggling in_valid.
   - out_vec/out_valid/sat_mask are stable and in_ready=0.
   - Raise out_ready -> one handshake; in_ready=1 on the next edge; the next vector is processed correctly.
5. Assert rst_n low during the 2nd MAC cycle -> out_valid, out_vec, sat_mask and busy read 0 immediately (asynchronously).
   - in_ready=0 until the first edge after release.
   - Scenario 1 then passes.
6. Build with FRAC_BITS=4: identity weights 8'h10, bias 0, in_vec=32'h20202020 -> out_vec=32'h20202020. Then in_vec=32'hF8F8F8F8 with weights 8'h01 on the diagonal -> (-8)>>>4 = -1 -> out_vec=32'hFFFFFFFF (floor rounding).
